// File: rtl/config_latch_sequencer_if.sv
// Peripheral register bus write port feeding the configuration latch sequencer.
interface config_latch_sequencer_if;
    logic        write_req;
    logic [5:0]  address;
    logic [31:0] data_in;

    modport master (output write_req, output address, output data_in);
    modport slave  (input  write_req, input  address, input  data_in);
endinterface

// File: rtl/config_latch_sequencer.sv
// Assembles a multi-word configuration value from bus writes and strobes a bank of
// latches with registered one-hot enables, either all of them (high to low) or one by index.
module config_latch_sequencer #(
    parameter int          NUM_REGS   = 8,
    parameter int          CFG_WORDS  = 2,
    parameter int          EN_CYCLES  = 1,
    parameter int          GAP_CYCLES = 1,
    parameter logic [5:0]  BASE_ADDR  = 6'h08,
    parameter logic [5:0]  CMD_ADDR   = 6'h04
) (
    input  logic                      clk,
    input  logic                      rst_n,
    config_latch_sequencer_if.slave   bus,
    output logic [32*CFG_WORDS-1:0]   config_data,
    output logic [NUM_REGS-1:0]       latch_en,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int IDX_W  = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1;
    localparam int WSEL_W = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(CFG_WORDS - 1);
    localparam logic [3:0] EN_LOAD  = 4'(EN_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   index;
    logic [3:0]         cnt;
    logic               single_mode;
    logic               word_hit;
    logic [WSEL_W-1:0]  word_sel;
    logic               cmd_hit;
    logic               cmd_valid;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int b = 0; b < NUM_REGS; b++) begin
            r[b] = (int'(i) == b);
        end
        return r;
    endfunction

    // Word k of the configuration value lives at BASE_ADDR + 4*k.
    always_comb begin
        word_hit = 1'b0;
        word_sel = '0;
        for (int k = 0; k < CFG_WORDS; k++) begin
            if (bus.address == 6'(int'(BASE_ADDR) + 4 * k)) begin
                word_hit = 1'b1;
                word_sel = WSEL_W'(k);
            end
        end
    end

    assign cmd_hit   = (bus.address == CMD_ADDR);
    assign cmd_valid = ({1'b0, bus.data_in[4:0]} < 6'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            index       <= '0;
            cnt         <= '0;
            single_mode <= 1'b0;
            config_data <= '0;
            latch_en    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.write_req && word_hit) begin
                        config_data[32*word_sel +: 32] <= bus.data_in;
                        if (word_sel == LAST_WORD) begin
                            state       <= PULSE;
                            busy        <= 1'b1;
                            cnt         <= EN_LOAD;
                            single_mode <= 1'b0;
                            index       <= IDX_W'(NUM_REGS - 1);
                            latch_en    <= onehot(IDX_W'(NUM_REGS - 1));
                        end
                    end else if (bus.write_req && cmd_hit) begin
                        if (cmd_valid) begin
                            state       <= PULSE;
                            busy        <= 1'b1;
                            cnt         <= EN_LOAD;
                            single_mode <= 1'b1;
                            index       <= bus.data_in[IDX_W-1:0];
                            latch_en    <= onehot(bus.data_in[IDX_W-1:0]);
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (bus.write_req && (word_hit || cmd_hit)) begin
                        error <= 1'b1;
                    end
                    if (cnt == 4'd0) begin
                        state    <= GAP;
                        cnt      <= GAP_LOAD;
                        latch_en <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (bus.write_req && (word_hit || cmd_hit)) begin
                        error <= 1'b1;
                    end
                    // Full loads walk the index down to 0 and stop there; no wrap.
                    if (cnt == 4'd0) begin
                        if (single_mode || index == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= PULSE;
                            cnt      <= EN_LOAD;
                            index    <= index - 1'b1;
                            latch_en <= onehot(index - 1'b1);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    latch_en <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_config_latch_sequencer.sv
// Bench for config_latch_sequencer: default instance plus a swept-parameter instance,
// both compared each cycle against a schedule model derived from trigger time.
module tb_config_latch_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    config_latch_sequencer_if bus_a();
    config_latch_sequencer_if bus_b();

    logic [63:0] cfg_a;
    logic [7:0]  le_a;
    logic        busy_a, done_a, err_a;
    logic [95:0] cfg_b;
    logic [4:0]  le_b;
    logic        busy_b, done_b, err_b;

    config_latch_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .config_data(cfg_a), .latch_en(le_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    config_latch_sequencer #(
        .NUM_REGS(5), .CFG_WORDS(3), .EN_CYCLES(3), .GAP_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .config_data(cfg_b), .latch_en(le_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int num   [2] = '{8, 5};
    int words [2] = '{2, 3};
    int en    [2] = '{1, 3};
    int gap   [2] = '{1, 2};

    bit            drv_wr   [2];
    logic [5:0]    drv_addr [2];
    logic [31:0]   drv_data [2];

    bit            trig    [2];
    int            t0      [2];
    int            idx0    [2];
    bit            single  [2];
    bit            err_exp [2];
    logic [255:0]  cfg     [2];

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input bit wr, input logic [5:0] a, input logic [31:0] dat);
        drv_wr[d]   = wr;
        drv_addr[d] = a;
        drv_data[d] = dat;
        if (d == 0) begin
            bus_a.write_req = wr; bus_a.address = a; bus_a.data_in = dat;
        end else begin
            bus_b.write_req = wr; bus_b.address = a; bus_b.data_in = dat;
        end
    endtask

    task automatic modelReset(input int d);
        trig[d]    = 1'b0;
        cfg[d]     = '0;
        err_exp[d] = 1'b0;
    endtask

    // What the bus write sampled at this edge means for instance d.
    task automatic modelEdge(input int d);
        int p, len, prev, wk;
        bit was_busy, is_word;
        logic [31:0] dat;
        err_exp[d] = 1'b0;
        if (!rst_n) begin
            modelReset(d);
            return;
        end
        p = en[d] + gap[d];
        len = single[d] ? p : num[d] * p;
        prev = cyc - 1 - t0[d];
        was_busy = trig[d] && prev >= 0 && prev < len;
        is_word = 1'b0;
        wk = 0;
        for (int k = 0; k < words[d]; k++) begin
            if (drv_addr[d] == 6'(8 + 4 * k)) begin
                is_word = 1'b1;
                wk = k;
            end
        end
        if (!drv_wr[d]) return;
        dat = drv_data[d];
        if (was_busy) begin
            if (is_word || drv_addr[d] == 6'h04) err_exp[d] = 1'b1;
        end else if (is_word) begin
            cfg[d][32*wk +: 32] = dat;
            if (wk == words[d] - 1) begin
                trig[d] = 1'b1; t0[d] = cyc; idx0[d] = num[d] - 1; single[d] = 1'b0;
            end
        end else if (drv_addr[d] == 6'h04) begin
            if (int'(dat[4:0]) < num[d]) begin
                trig[d] = 1'b1; t0[d] = cyc; idx0[d] = int'(dat[4:0]); single[d] = 1'b1;
            end else begin
                err_exp[d] = 1'b1;
            end
        end
    endtask

    task automatic checkDut(input int d);
        logic [255:0] o_cfg, o_le, e_le;
        logic o_busy, o_done, o_err;
        bit e_busy, e_done;
        int r, p, len;
        string n;
        if (d == 0) begin
            o_cfg = 256'(cfg_a); o_le = 256'(le_a); o_busy = busy_a; o_done = done_a; o_err = err_a; n = "A";
        end else begin
            o_cfg = 256'(cfg_b); o_le = 256'(le_b); o_busy = busy_b; o_done = done_b; o_err = err_b; n = "B";
        end
        p = en[d] + gap[d];
        len = single[d] ? p : num[d] * p;
        r = cyc - t0[d];
        e_le = '0;
        e_busy = trig[d] && r >= 0 && r < len;
        e_done = trig[d] && r == len;
        if (e_busy && (r % p) < en[d]) begin
            e_le[single[d] ? idx0[d] : num[d] - 1 - r / p] = 1'b1;
        end
        checkOutput($sformatf("%s.latch_en@%0d", n, cyc), o_le, e_le);
        checkOutput($sformatf("%s.busy@%0d", n, cyc), 256'(o_busy), 256'(e_busy));
        checkOutput($sformatf("%s.done@%0d", n, cyc), 256'(o_done), 256'(e_done));
        checkOutput($sformatf("%s.error@%0d", n, cyc), 256'(o_err), 256'(err_exp[d]));
        checkOutput($sformatf("%s.config_data@%0d", n, cyc), o_cfg, cfg[d]);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        modelEdge(0);
        modelEdge(1);
        #1;
        checkDut(0);
        checkDut(1);
        @(negedge clk);
        applyStimulus(0, 1'b0, drv_addr[0], drv_data[0]);
        applyStimulus(1, 1'b0, drv_addr[1], drv_data[1]);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    function automatic logic [5:0] randAddr();
        logic [5:0] list [7];
        list = '{6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h00, 6'h3C};
        return list[$urandom_range(0, 6)];
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0]  a;
        logic [31:0] dat;
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b0, 6'h00, 32'h0);
            modelReset(d);
            t0[d] = 0; idx0[d] = 0; single[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Bus traffic while reset is held must have no effect.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, randAddr(), $urandom());
            applyStimulus(1, 1'b1, randAddr(), $urandom());
            cycle();
        end
        rst_n = 1'b1;
        idle(3);

        // Full load on the default instance.
        applyStimulus(0, 1'b1, 6'h08, 32'h11223344);
        cycle();
        applyStimulus(0, 1'b1, 6'h0C, 32'h55667788);
        cycle();
        checkOutput("full.config_data", 256'(cfg_a), 256'(64'h5566778811223344));
        checkOutput("full.first_enable", 256'(le_a), 256'(8'h80));
        idle(18);

        // Single latch reload, then an out-of-range index.
        applyStimulus(0, 1'b1, 6'h04, 32'h00000003);
        cycle();
        checkOutput("single.enable", 256'(le_a), 256'(8'h08));
        idle(4);
        applyStimulus(0, 1'b1, 6'h04, 32'h00000009);
        cycle();
        idle(3);

        // Writes during a full load are dropped.
        applyStimulus(0, 1'b1, 6'h0C, 32'hA5A5A5A5);
        cycle();
        idle(2);
        applyStimulus(0, 1'b1, 6'h08, 32'hDEADBEEF);
        cycle();
        idle(1);
        applyStimulus(0, 1'b1, 6'h04, 32'h00000002);
        cycle();
        idle(18);

        // Reset in the middle of a full load, while latch 5 is enabled.
        applyStimulus(0, 1'b1, 6'h08, 32'hCAFEF00D);
        cycle();
        applyStimulus(0, 1'b1, 6'h0C, 32'h0BADC0DE);
        cycle();
        idle(4);
        checkOutput("rstmid.pre_enable", 256'(le_a), 256'(8'h20));
        rst_n = 1'b0;
        #1;
        modelReset(0);
        modelReset(1);
        checkOutput("rstmid.latch_en", 256'(le_a), 256'(0));
        checkOutput("rstmid.busy", 256'(busy_a), 256'(0));
        checkOutput("rstmid.config_data", 256'(cfg_a), 256'(0));
        idle(2);
        rst_n = 1'b1;
        idle(6);

        // Swept instance: three words, trigger on the write to 0x10.
        applyStimulus(1, 1'b1, 6'h08, 32'h01020304);
        cycle();
        applyStimulus(1, 1'b1, 6'h0C, 32'h05060708);
        cycle();
        applyStimulus(1, 1'b1, 6'h10, 32'h090A0B0C);
        cycle();
        checkOutput("sweep.config_data", 256'(cfg_b), 256'(96'h090A0B0C0506070801020304));
        idle(28);

        // Random traffic on both instances.
        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = randAddr();
                    dat = $urandom();
                    if (a == 6'h04) dat[4:0] = 5'($urandom_range(0, 12));
                    applyStimulus(d, 1'b1, a, dat);
                end
            end
            cycle();
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
